// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmitter and receiver:
//                frame state encoding, parity-select encoding and the
//                clocks-per-bit helper used to size the baud counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame phases, in line order. uart_rx walks the same sequence.
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Encoding of the parity_sel input.
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Whole system clocks per line bit. Truncation is deliberate: the
    // residual error is bounded per bit because counters reload each bit.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Reloadable down-counter producing one tick per bit period.
//                The tick is asserted during the last clock of a bit period,
//                so the owner advances on the edge that ends the bit.
//  Ports       : i_clk    - system clock
//                i_rst_n  - asynchronous active-low reset
//                i_run    - count enable; the counter holds while low
//                i_reload - restart the bit period (has priority over i_run)
//                o_tick   - high in the final clock of each bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_reload,
    output logic o_tick
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_reload) begin
            r_count <= c_RELOAD;
        end else if (i_run) begin
            // Self-reload keeps consecutive bit periods exactly equal even
            // when the owner does not request an explicit reload.
            if (r_count == '0) begin
                r_count <= c_RELOAD;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_tick = i_run && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter. Accepts one word per valid/ready
//                handshake and serialises it LSB first on an idle-high line:
//                start bit, p_data_bits data bits, optional parity bit,
//                then one or two stop bits.
//  Ports       : clk_i        - system clock
//                rst_n_i      - asynchronous active-low reset
//                enable_i     - gates acceptance of new words only
//                tx_valid_i   - word on tx_data_i is to be sent
//                tx_data_i    - word to send, LSB first
//                tx_ready_o   - a word is accepted this cycle if valid
//                parity_en_i  - insert a parity bit after the data
//                parity_sel_i - 1 odd parity, 0 even parity
//                stop_bits_i  - 0 one stop bit, 1 two stop bits
//                tx_o         - serial line
//                busy_o       - frame in progress
//                done_o       - one-cycle pulse as the frame completes
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int p_clk_speed_hz = 50_000_000,
    parameter int p_baud_rate    = 9_600,
    parameter int p_data_bits    = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   enable_i,
    input  logic                   tx_valid_i,
    input  logic [p_data_bits-1:0] tx_data_i,
    output logic                   tx_ready_o,
    input  logic                   parity_en_i,
    input  logic                   parity_sel_i,
    input  logic                   stop_bits_i,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int c_CLKS_PER_BIT = clks_per_bit(p_clk_speed_hz, p_baud_rate);
    localparam int c_IDX_W        = $clog2(p_data_bits);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(p_data_bits - 1);

    // ------------------------------------------------------------------
    // Elaboration-time configuration checks
    // ------------------------------------------------------------------
    if (c_CLKS_PER_BIT < 2) begin : g_chk_clks_per_bit
        $error("uart_tx: clock/baud ratio must give at least 2 clocks per bit");
    end

    if ((p_data_bits < 5) || (p_data_bits > 8)) begin : g_chk_data_bits
        $error("uart_tx: p_data_bits must lie in 5..8");
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    tx_state_t              r_state;
    logic [p_data_bits-1:0] r_shift;        // remaining data, bit 0 on line
    logic [c_IDX_W-1:0]     r_bit_idx;      // data bit currently on line
    logic                   r_parity_bit;   // parity value fixed at accept
    logic                   r_parity_en;
    logic                   r_stop_two;
    logic                   r_stop_second;  // second stop bit in progress
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_done;

    // ------------------------------------------------------------------
    // Handshake and bit timing
    // ------------------------------------------------------------------
    logic w_ready;
    logic w_accept;
    logic w_tick;
    logic w_run;
    logic w_reload;

    // Ready is held low while reset is asserted even though the state
    // register already reads IDLE, so no word is taken during reset.
    assign w_ready  = rst_n_i & enable_i & (r_state == TX_IDLE);
    assign w_accept = tx_valid_i & w_ready;
    assign w_run    = (r_state != TX_IDLE);
    // Restart the bit period on acceptance and on every bit boundary so
    // every bit lasts exactly c_CLKS_PER_BIT clocks.
    assign w_reload = w_accept | w_tick;

    uart_baud_tick #(
        .CLKS_PER_BIT (c_CLKS_PER_BIT)
    ) u_baud_tick (
        .i_clk    (clk_i),
        .i_rst_n  (rst_n_i),
        .i_run    (w_run),
        .i_reload (w_reload),
        .o_tick   (w_tick)
    );

    // ------------------------------------------------------------------
    // Frame state machine with registered line, busy and done outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= TX_IDLE;
            r_shift       <= '0;
            r_bit_idx     <= '0;
            r_parity_bit  <= 1'b0;
            r_parity_en   <= 1'b0;
            r_stop_two    <= 1'b0;
            r_stop_second <= 1'b0;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        // Snapshot everything the frame needs; the inputs
                        // are free to change from here on.
                        r_shift       <= tx_data_i;
                        r_parity_bit  <= (^tx_data_i) ^ (parity_sel_i == PARITY_ODD);
                        r_parity_en   <= parity_en_i;
                        r_stop_two    <= stop_bits_i;
                        r_stop_second <= 1'b0;
                        r_bit_idx     <= '0;
                        r_state       <= TX_START;
                        r_tx          <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end

                TX_START: begin
                    if (w_tick) begin
                        r_state   <= TX_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                    end
                end

                TX_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == c_LAST_IDX) begin
                            r_bit_idx <= '0;
                            if (r_parity_en) begin
                                r_state <= TX_PARITY;
                                r_tx    <= r_parity_bit;
                            end else begin
                                r_state       <= TX_STOP;
                                r_stop_second <= 1'b0;
                                r_tx          <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            // Bit 1 becomes bit 0 after this shift.
                            r_tx      <= r_shift[1];
                        end
                    end
                end

                TX_PARITY: begin
                    if (w_tick) begin
                        r_state       <= TX_STOP;
                        r_stop_second <= 1'b0;
                        r_tx          <= 1'b1;
                    end
                end

                TX_STOP: begin
                    r_tx <= 1'b1;
                    if (w_tick) begin
                        if (r_stop_two && !r_stop_second) begin
                            r_stop_second <= 1'b1;
                        end else begin
                            r_stop_second <= 1'b0;
                            r_state       <= TX_IDLE;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= TX_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_ready_o = w_ready;
    assign tx_o       = r_tx;
    assign busy_o     = r_busy;
    assign done_o     = r_done;

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter: serialises one data word per request onto a single idle-high line, with optional parity and 1 or 2 stop bits. It is the upstream peer of uart_rx and uses the same frame format and configuration inputs, so a tx→rx loopback needs no glue. Bus-side logic feeds it through a valid/ready handshake; the line output drives the pad or loopback wire.

Parameters:
p_clk_speed_hz, 50_000_000, system clock frequency in Hz
p_baud_rate, 9_600, line bit rate in bits/s
p_data_bits, 7, data bits per frame (legal range 5..8)

Ports:
clk_i  input  1  system clock, single clock domain
rst_n_i  input  1  reset, asynchronous, active-low
enable_i  input  1  when 0, no new frame is accepted; a frame already in flight completes
tx_valid_i  input  1  request to send tx_data_i
tx_data_i  input  p_data_bits  word to send, LSB first
tx_ready_o  output  1  block can accept a word this cycle
parity_en_i  input  1  1 = insert parity bit after data
parity_sel_i  input  1  1 = odd parity, 0 = even parity
stop_bits_i  input  1  0 = one stop bit, 1 = two stop bits
tx_o  output  1  serial line, idle high
busy_o  output  1  frame in progress
done_o  output  1  one-cycle pulse at end of frame

Behaviour:
- Constant CLKS_PER_BIT = p_clk_speed_hz / p_baud_rate (integer division). Elaborate-time assertion that CLKS_PER_BIT >= 2.
- Reset (async assert, sync release): state IDLE; tx_o=1; busy_o=0; done_o=0; tx_ready_o=0 during reset; all counters 0.
- tx_ready_o = (state==IDLE) & enable_i. This is combinational from the state register and enable_i.
- Accept: a word is accepted on the rising edge where tx_valid_i & tx_ready_o. On that edge, latch tx_data_i, parity_en_i, parity_sel_i and stop_bits_i into shadow registers. Input changes after acceptance have no effect on the frame in flight.
- Latency: tx_o goes low and busy_o goes high on the edge after acceptance. Both are registered outputs.
- State machine: IDLE → START → DATA → (PARITY if parity_en) → STOP → IDLE.
  - Each state holds tx_o for exactly CLKS_PER_BIT cycles.
  - START drives 0.
  - DATA drives shift_reg[0], shifting right each bit for p_data_bits bits. The bit index counter wraps 0..p_data_bits-1.
  - PARITY drives ^data XOR parity_sel, so parity_sel=1 makes the total ones count odd.
  - STOP drives 1 for 1 or 2 bit times per the latched stop_bits.
- Frame length in clocks = CLKS_PER_BIT × (1 + p_data_bits + parity_en + 1 + stop_bits).
- done_o pulses high for exactly one cycle, on the cycle where STOP returns to IDLE. busy_o falls on that same edge.
- Back-to-back: if tx_valid_i is held high, the next word is accepted in the first IDLE cycle. This gives exactly one idle clock (tx_o=1) between frames.
- enable_i falling mid-frame: the frame finishes normally and no new word is accepted.
- Reset mid-frame: tx_o=1 immediately (asynchronous). The frame is abandoned and done_o is not pulsed.
- The baud counter is a down-counter of width $clog2(CLKS_PER_BIT). It is reloaded on every state change, so there is no cumulative drift.

Decomposition:
- Package uart_pkg:
  - typedef enum for tx states (IDLE, START, DATA, PARITY, STOP), shared with uart_rx.
  - Function clks_per_bit(clk_hz, baud).
  - Parity select encoding constants PARITY_EVEN=0, PARITY_ODD=1.
- One sub-module, uart_baud_tick: reloadable down-counter that emits a bit-period tick. It is reusable by uart_rx for mid-bit sampling.

Test Plan:
- Bench setup: p_clk_speed_hz=1_000_000, p_baud_rate=100_000 (10 clk/bit), p_data_bits=7.
- Send 7'b1010011, parity_en=1, sel=1 (odd), stop=0 → tx_o sequence 0,1,1,0,0,1,0,1,1,1 at 10 clk each. Each bit is sampled at mid-bit. done_o pulses once at clock 100 after acceptance; busy_o is high for 100 clocks.
- Send 7'h00, parity_en=1, sel=0 (even), stop=1 → frame is 0, seven 0s, parity 0, 1, 1 (110 clocks). Changing parity_sel_i mid-frame does not alter the parity bit.
- Back-to-back 7'h55 then 7'h2A, tx_valid_i held high, no parity, 1 stop → two 90-clock frames with exactly 1 idle-high clock between them and two done_o pulses. A uart_rx loopback returns 0x55 and 0x2A with no framing or parity errors.
- enable_i=0 with tx_valid_i=1 → tx_ready_o=0 and tx_o stays 1 for 200 clocks. Raising enable_i starts the frame on the next edge.
- Assert rst_n_i low at clock 35 of a frame → tx_o=1 and busy_o=0 within the same cycle, asynchronously. There is no done_o pulse. After release, a new frame transmits correctly.
